hotel_checkout: RTL
===================

// Module: hotel_checkout
// PURPOSE
//  Checkout engine paired with the booking block: takes a customer ID + stay length,
//  scans the live room-occupancy table for that ID, computes the final bill
//  (nightly rate incl. AC/Wi-Fi x days) with a shift-add multiplier, pulses a release
//  to the booking block so the room returns to 4'b0000, then returns a response.
// PARAMETERS
//  ID_W       4   customer ID width (ID 0 = vacant / invalid)
//  NUM_ROOMS  7   rooms in table; index 0..6 = room1,room2,room3_1,room3_2,room4_1,room4_2,room5
//  DAYS_W     3   stay-length width
//  BILL_W     16  bill width
// PORTS
//  clk           in   1              rising-edge clock
//  rst           in   1              asynchronous, active-high reset
//  req_valid     in   1              checkout request
//  req_ready     out  1              high only in IDLE
//  req_id        in   ID_W           customer ID to check out
//  req_days      in   DAYS_W         nights stayed
//  room_ids      in   NUM_ROOMS*ID_W occupancy table; slot i at [i*ID_W +: ID_W]
//  room_ac_wifi  in   NUM_ROOMS*2    per-room {ac,wifi}; slot i at [i*2 +: 2]
//  release_valid out  1              one-cycle pulse: free room release_room
//  release_room  out  3              room code 1..7 (= index+1, booking encoding)
//  rsp_valid     out  1              response valid, held until rsp_ready
//  rsp_ready     in   1              response accept
//  rsp_found     out  1              ID was found in the table
//  rsp_room      out  3              room code freed (0 if not found)
//  rsp_bill      out  BILL_W         final bill (0 if not found)
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready, release_valid, rsp_valid, rsp_found = 0;
//    release_room, rsp_room, rsp_bill = 0; internal regs cleared. req_ready rises
//    first edge after rst deasserts. All outputs registered.
//  - States: IDLE, SCAN, MULT, RELEASE, RESP.
//  - IDLE: req_ready=1. Accept on edge T with req_valid&req_ready: latch id, days.
//    id==0 -> RESP (found=0, room=0, bill=0). Else -> SCAN, idx=0.
//  - SCAN: one slot per cycle, table sampled live. Slot idx matches -> latch
//    room=idx+1, rate=base+200*ac+100*wifi -> MULT. Base: idx0,1=700; idx2..5=400;
//    idx6=500. Lowest index wins. No match at idx=NUM_ROOMS-1 -> RESP, found=0.
//  - MULT: exactly DAYS_W cycles, bit k of days (LSB first): acc += rate<<k;
//    result truncated to BILL_W (max 900*7=6300, no overflow at defaults). -> RELEASE.
//  - RELEASE: release_valid=1, release_room=room for exactly one cycle -> RESP.
//  - RESP: rsp_valid=1, rsp_* stable until rsp_ready; edge with rsp_ready -> IDLE,
//    rsp_valid drops next cycle. req_valid ignored outside IDLE.
//  - Latency (match at index i): rsp_valid high 2+i+DAYS_W cycles after accept edge
//    (release_valid 1 cycle earlier). Not found: NUM_ROOMS cycles. id==0: 1 cycle.
//  - days==0 with match: bill=0, room still released, found=1.
//  - Table changes during SCAN: only the slot compared in that cycle counts.
//  - rst mid-operation: immediate return to reset values; no release pulse issued,
//    in-flight request dropped.
// TESTING
//  1. room_ids slot3=5, ac_wifi slot3=2'b11, req id=5 days=3 -> one release pulse
//     room=3'b100; rsp found=1 room=4 bill=2100; rsp_valid 8 cycles after accept.
//  2. req id=9 absent from table -> no release pulse; rsp found=0 room=0 bill=0;
//     rsp_valid 7 cycles after accept.
//  3. slot6=7, ac_wifi=00, id=7 days=7 -> release room=3'b111, bill=3500.
//  4. rsp_ready low 5 cycles in RESP -> rsp_* stable, req_ready=0, pulsed req_valid
//     not accepted; rsp_ready high -> IDLE, req_ready=1 next cycle.
//  5. id=0 -> found=0 one cycle after accept; slot0=2, id=2 days=0 -> bill=0,
//     release room=3'b001, found=1.
//  6. rst asserted during MULT -> all outputs 0 at once, no release_valid;
//     after deassert, test 1 request completes with correct results.

Source files
------------

// File: rtl/hotel_checkout.sv
// Checkout engine: scans the occupancy table for a customer ID, bills rate x nights
// with a shift-add multiplier, pulses a room release, then holds a response.
module hotel_checkout #(
   parameter int ID_W      = 4,
   parameter int NUM_ROOMS = 7,
   parameter int DAYS_W    = 3,
   parameter int BILL_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [ID_W-1:0]           req_id,
   input  logic [DAYS_W-1:0]         req_days,
   input  logic [NUM_ROOMS*ID_W-1:0] room_ids,
   input  logic [NUM_ROOMS*2-1:0]    room_ac_wifi,
   output logic                      release_valid,
   output logic [2:0]                release_room,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_found,
   output logic [2:0]                rsp_room,
   output logic [BILL_W-1:0]         rsp_bill
);

   localparam int IDX_W  = 3;
   localparam int RATE_W = 10;
   localparam int K_W    = (DAYS_W > 1) ? $clog2(DAYS_W) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SCAN    = 3'd1,
      S_MULT    = 3'd2,
      S_RELEASE = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [DAYS_W-1:0]   days_q, days_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [K_W-1:0]      k_q, k_d;
   logic [RATE_W-1:0]   rate_q, rate_d;
   logic [2:0]          room_q, room_d;
   logic                found_q, found_d;
   logic [BILL_W-1:0]   acc_q, acc_d;

   logic                req_ready_q, req_ready_d;
   logic                release_valid_q, release_valid_d;
   logic [2:0]          release_room_q, release_room_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_found_q, rsp_found_d;
   logic [2:0]          rsp_room_q, rsp_room_d;
   logic [BILL_W-1:0]   rsp_bill_q, rsp_bill_d;

   logic [ID_W-1:0]     slot_id_s;
   logic [1:0]          slot_acw_s;

   // Nightly rate: room-class base plus 200 for AC and 100 for Wi-Fi.
   function automatic logic [RATE_W-1:0] rate_of(input logic [IDX_W-1:0] idx,
                                                 input logic [1:0] acw);
      logic [RATE_W-1:0] base;
      case (idx)
         3'd0, 3'd1:             base = 10'd700;
         3'd2, 3'd3, 3'd4, 3'd5: base = 10'd400;
         3'd6:                   base = 10'd500;
         default:                base = 10'd0;
      endcase
      return base + (acw[1] ? 10'd200 : 10'd0) + (acw[0] ? 10'd100 : 10'd0);
   endfunction

   // The table is sampled live: only the slot under the scan pointer matters this cycle.
   assign slot_id_s  = room_ids[idx_q*ID_W +: ID_W];
   assign slot_acw_s = room_ac_wifi[idx_q*2 +: 2];

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      days_d  = days_q;
      idx_d   = idx_q;
      k_d     = k_q;
      rate_d  = rate_q;
      room_d  = room_q;
      found_d = found_q;
      acc_d   = acc_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               id_d    = req_id;
               days_d  = req_days;
               idx_d   = '0;
               k_d     = '0;
               rate_d  = '0;
               room_d  = 3'd0;
               found_d = 1'b0;
               acc_d   = '0;
               state_d = S_SCAN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SCAN: begin
            // ID 0 means vacant, so it can never match; answer after one cycle.
            if (id_q == '0) begin
               state_d = S_RESP;
            end else if (slot_id_s == id_q) begin
               found_d = 1'b1;
               room_d  = idx_q + 3'd1;
               rate_d  = rate_of(idx_q, slot_acw_s);
               k_d     = '0;
               state_d = S_MULT;
            end else if (idx_q == IDX_W'(NUM_ROOMS - 1)) begin
               state_d = S_RESP;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         S_MULT: begin
            if (days_q[k_q]) begin
               acc_d = acc_q + (BILL_W'(rate_q) << k_q);
            end else begin
               acc_d = acc_q;
            end
            if (k_q == K_W'(DAYS_W - 1)) begin
               state_d = S_RELEASE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_RELEASE: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs follow the state being entered so they line up with it.
      req_ready_d     = (state_d == S_IDLE);
      release_valid_d = (state_d == S_RELEASE);
      release_room_d  = (state_d == S_RELEASE) ? room_q : 3'd0;
      rsp_valid_d     = (state_d == S_RESP);
      rsp_found_d     = (state_d == S_RESP) ? found_q : 1'b0;
      rsp_room_d      = (state_d == S_RESP) ? room_q : 3'd0;
      rsp_bill_d      = (state_d == S_RESP) ? acc_q : '0;
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         id_q            <= '0;
         days_q          <= '0;
         idx_q           <= '0;
         k_q             <= '0;
         rate_q          <= '0;
         room_q          <= 3'd0;
         found_q         <= 1'b0;
         acc_q           <= '0;
         req_ready_q     <= 1'b0;
         release_valid_q <= 1'b0;
         release_room_q  <= 3'd0;
         rsp_valid_q     <= 1'b0;
         rsp_found_q     <= 1'b0;
         rsp_room_q      <= 3'd0;
         rsp_bill_q      <= '0;
      end else begin
         state_q         <= state_d;
         id_q            <= id_d;
         days_q          <= days_d;
         idx_q           <= idx_d;
         k_q             <= k_d;
         rate_q          <= rate_d;
         room_q          <= room_d;
         found_q         <= found_d;
         acc_q           <= acc_d;
         req_ready_q     <= req_ready_d;
         release_valid_q <= release_valid_d;
         release_room_q  <= release_room_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_found_q     <= rsp_found_d;
         rsp_room_q      <= rsp_room_d;
         rsp_bill_q      <= rsp_bill_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign release_valid = release_valid_q;
   assign release_room  = release_room_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_found     = rsp_found_q;
   assign rsp_room      = rsp_room_q;
   assign rsp_bill      = rsp_bill_q;

endmodule
